// File: rtl/switch_hex_debounce.sv
// switch_hex_debounce: synchronise and debounce NUM_CH slide switches onto LEDs and active-low 7-segment digits
//   CLOCK_50 : system clock, all state on the rising edge
//   RESET    : asynchronous active-high reset
//   SW       : raw switch levels, asynchronous to CLOCK_50
//   MODE     : 0 = digits show debounced state, 1 = digits show 4-bit rising-edge count
//   CLR_CNT  : synchronous clear of every edge counter
//   LEDR     : debounced switch state, bit i = channel i
//   HEX      : byte i = HEX[8*i+7:8*i] = {dp, g..a}, active-low
//   Optional: define SWHEX_DP_PULSE_EN to light each digit's DP for PULSE_CYCLES after a debounced transition
module switch_hex_debounce #(
    parameter int NUM_CH          = 6,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PULSE_CYCLES    = 12500000
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic [NUM_CH-1:0]   SW,
    input  logic                MODE,
    input  logic                CLR_CNT,
    output logic [NUM_CH-1:0]   LEDR,
    output logic [8*NUM_CH-1:0] HEX
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    // Segment patterns g..a (plus DP off) for 0..F, digit 0 in the lowest byte
    localparam logic [127:0] SEG = 128'h8E86A1C6_83889080_F8829299_B0A4F9C0;

    logic [NUM_CH-1:0]   sync1_q, sync2_q, stable_q, stable_d, dp;
    logic [CW-1:0]       db_q [NUM_CH];
    logic [CW-1:0]       db_d [NUM_CH];
    logic [3:0]          cnt_q [NUM_CH];
    logic [3:0]          cnt_d [NUM_CH];
    logic [8*NUM_CH-1:0] hex_q, hex_d;

    // Any cycle of agreement with the accepted level restarts the stability count
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_CH; i++) begin
            db_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_q[i] == CW'(DEBOUNCE_CYCLES - 1)) stable_d[i] = sync2_q[i];
                else db_d[i] = db_q[i] + 1'b1;
            end
            cnt_d[i] = CLR_CNT ? 4'd0 : (stable_d[i] && !stable_q[i]) ? cnt_q[i] + 4'd1 : cnt_q[i];
        end
    end

    always_comb begin
        hex_d = '1;
        for (int i = 0; i < NUM_CH; i++)
            hex_d[8*i +: 8] = {dp[i], MODE ? SEG[{cnt_q[i], 3'b000} +: 7] : (stable_q[i] ? 7'h79 : 7'h40)};
    end

`ifdef SWHEX_DP_PULSE_EN
    localparam int PW = $clog2(PULSE_CYCLES + 1);

    logic [PW-1:0] pulse_q [NUM_CH];
    logic [PW-1:0] pulse_d [NUM_CH];

    // DP is lit on the transition edge itself and while the reloaded window runs down
    always_comb begin
        dp = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            pulse_d[i] = (stable_d[i] != stable_q[i]) ? PW'(PULSE_CYCLES - 1) :
                         (pulse_q[i] != '0) ? pulse_q[i] - 1'b1 : pulse_q[i];
            dp[i] = (stable_d[i] == stable_q[i]) && (pulse_q[i] == '0);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_CH; i++) pulse_q[i] <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end
`else
    // PULSE_CYCLES only matters when the pulse feature is built in
    logic unused_pulse;
    assign unused_pulse = ^PULSE_CYCLES;
    assign dp = '1;
`endif

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            hex_q    <= {NUM_CH{8'hC0}};
            for (int i = 0; i < NUM_CH; i++) begin
                db_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= SW;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            hex_q    <= hex_d;
            db_q     <= db_d;
            cnt_q    <= cnt_d;
        end
    end

    assign LEDR = stable_q;
    assign HEX  = hex_q;
endmodule

// File: tb/tb_switch_hex_debounce.sv
// tb_switch_hex_debounce: directed table, hand sequences and random stimulus against a reference model
module tb_switch_hex_debounce;
    localparam int N = 6;
    localparam int D = 4;
    localparam int P = 3;
    localparam int H = D + 2;
    localparam logic [8*N-1:0] MASK = {N{8'h7F}};
    localparam logic [8*N-1:0] ALL_C0 = {N{8'hC0}};

    typedef struct {
        logic [N-1:0]   sw;
        logic           mode;
        logic           clr;
        int             n;
        logic [N-1:0]   ledr;
        logic [8*N-1:0] hex;
    } vec_t;

    logic clk = 0;
    logic rst = 1;
    logic mode = 0;
    logic clr = 0;
    logic [N-1:0] sw = 6'h3F;
    logic [N-1:0] ledr;
    logic [8*N-1:0] hex;

    switch_hex_debounce #(.NUM_CH(N), .DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P)) dut (
        .CLOCK_50(clk),
        .RESET(rst),
        .SW(sw),
        .MODE(mode),
        .CLR_CNT(clr),
        .LEDR(ledr),
        .HEX(hex)
    );

    always #5 clk = ~clk;

    logic [7:0] seg [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
`ifdef SWHEX_DP_PULSE_EN
    logic dp_exp [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    logic dp_exp [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

    int n_pass = 0;
    int n_total = 0;
    int ecnt = 0;
    logic [N-1:0] m_st;
    logic [N-1:0] hist [H];
    logic [3:0] m_cnt [N];
    int t_last [N];
    logic [8*N-1:0] m_hex;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @edge %0d: got %h want %h", name, ecnt, act, exp);
    endtask

    task automatic model_reset();
        m_st = '0;
        m_hex = ALL_C0;
        for (int j = 0; j < H; j++) hist[j] = '0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 4'd0;
            t_last[i] = -100;
        end
    endtask

    // hist[j] is SW as sampled j edges ago; the level accepted at an edge is the
    // one seen after two sync stages for D straight samples
    task automatic model_edge();
        logic [N-1:0] old_st;
        logic [3:0] old_cnt [N];
        logic flip;
        logic [7:0] dig;
        old_st = m_st;
        old_cnt = m_cnt;
        for (int j = H - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = sw;
        for (int i = 0; i < N; i++) begin
            flip = 1'b1;
            for (int j = 2; j < H; j++) if (hist[j][i] == m_st[i]) flip = 1'b0;
            if (flip) begin
                m_st[i] = ~m_st[i];
                t_last[i] = ecnt;
                if (m_st[i]) m_cnt[i] = m_cnt[i] + 4'd1;
            end
            if (clr) m_cnt[i] = 4'd0;
            dig = mode ? seg[old_cnt[i]] : seg[{3'b000, old_st[i]}];
`ifdef SWHEX_DP_PULSE_EN
            if (ecnt - t_last[i] < P) dig[7] = 1'b0;
`endif
            m_hex[8*i +: 8] = dig;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        ecnt++;
        if (rst) model_reset();
        else model_edge();
        #1;
        chk("ledr", ledr, m_st);
        chk("hex", hex, m_hex);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_reset();
        #3 rst = 1;
        #1;
        chk("rst_ledr", ledr, 0);
        chk("rst_hex", hex, ALL_C0);
        model_reset();
        #1 rst = 0;
    endtask

    initial begin
        logic [7:0] b;
        tbl = '{
            '{6'h3F, 1'b0, 1'b0, 5, 6'h00, 48'hC0C0C0C0C0C0},
            '{6'h3F, 1'b0, 1'b0, 1, 6'h3F, 48'hC0C0C0C0C0C0},
            '{6'h3F, 1'b0, 1'b0, 1, 6'h3F, 48'hF9F9F9F9F9F9},
            '{6'h00, 1'b0, 1'b0, 6, 6'h00, 48'hF9F9F9F9F9F9},
            '{6'h00, 1'b0, 1'b0, 1, 6'h00, 48'hC0C0C0C0C0C0},
            '{6'h01, 1'b0, 1'b0, 3, 6'h00, 48'hC0C0C0C0C0C0},
            '{6'h00, 1'b0, 1'b0, 8, 6'h00, 48'hC0C0C0C0C0C0},
            '{6'h01, 1'b0, 1'b0, 5, 6'h00, 48'hC0C0C0C0C0C0},
            '{6'h01, 1'b0, 1'b0, 1, 6'h01, 48'hC0C0C0C0C0C0},
            '{6'h01, 1'b0, 1'b0, 4, 6'h01, 48'hC0C0C0C0C0F9},
            '{6'h01, 1'b1, 1'b1, 1, 6'h01, 48'hF9F9F9F9F9A4},
            '{6'h01, 1'b1, 1'b0, 1, 6'h01, 48'hC0C0C0C0C0C0}
        };
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("por_ledr", ledr, 0);
        chk("por_hex", hex, ALL_C0);
        #2 rst = 0;
        foreach (tbl[r]) begin
            sw = tbl[r].sw;
            mode = tbl[r].mode;
            clr = tbl[r].clr;
            ticks(tbl[r].n);
            chk($sformatf("row%0d_ledr", r), ledr, tbl[r].ledr);
            chk($sformatf("row%0d_hex", r), hex & MASK, tbl[r].hex & MASK);
        end
        for (int k = 0; k < 17; k++) begin
            sw = 6'h05;
            ticks(9);
            b = seg[(k + 1) % 16];
            chk("wrap_byte", hex[23:16] & 8'h7F, b & 8'h7F);
            sw = 6'h01;
            ticks(9);
            chk("wrap_all", hex & MASK, {24'hC0C0C0, b, 16'hC0C0} & MASK);
        end
        chk("wrap_end", hex[23:16] & 8'h7F, 8'hF9 & 8'h7F);
        repeat (5) begin
            sw = 6'h03;
            ticks(9);
            sw = 6'h01;
            ticks(9);
        end
        chk("clr_pre", hex[15:8] & 8'h7F, 8'h92 & 8'h7F);
        sw = 6'h03;
        ticks(5);
        clr = 1;
        tick();
        clr = 0;
        chk("clr_rise", ledr, 6'h03);
        ticks(3);
        chk("clr_hex", hex & MASK, ALL_C0 & MASK);
        repeat (9) begin
            sw = 6'h0B;
            ticks(9);
            sw = 6'h03;
            ticks(9);
        end
        sw = 6'h0B;
        ticks(9);
        chk("mode1_hex", hex & MASK, 48'hC0C088C0C0C0 & MASK);
        mode = 0;
        tick();
        chk("mode0_hex", hex & MASK, 48'hC0C0F9C0F9F9 & MASK);
        mode = 1;
        tick();
        chk("mode1b_hex", hex & MASK, 48'hC0C088C0C0C0 & MASK);
        sw = 6'h1B;
        ticks(4);
        sw = 6'h0B;
        for (int k = 5; k <= 13; k++) begin
            tick();
            chk($sformatf("dp_edge%0d", k), hex[39], dp_exp[k-5]);
        end
        sw = 6'h2B;
        ticks(3);
        pulse_reset();
        ticks(5);
        chk("rrel_ledr5", ledr, 0);
        tick();
        chk("rrel_ledr6", ledr, 6'h2B);
        tick();
        chk("rrel_hex", hex & MASK, 48'hF9C0F9C0F9F9 & MASK);
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 9) < 2) sw[i] = ~sw[i];
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            clr = ($urandom_range(0, 29) == 0);
            if (k == 700) pulse_reset();
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
